// File: rtl/gf180mcu_osu_sc_gp12t3v3__strap_pkg.sv
// rtl/gf180mcu_osu_sc_gp12t3v3__strap_pkg.sv - shared types and widths for the strap controller
// Holds the controller state encoding and the counter width constants.
package gf180mcu_osu_sc_gp12t3v3__strap_pkg;

  localparam int SETTLE_CNT_W = 8;
  localparam int RETRY_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_SAMPLE1 = 2'd1,
    ST_SAMPLE2 = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__strap_cnt.sv
// rtl/gf180mcu_osu_sc_gp12t3v3__strap_cnt.sv - loadable up-counter with terminal-count flag
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, clears the count
//   load     - load load_val (has priority over inc)
//   load_val - value loaded on load
//   inc      - increment by one
//   term     - terminal value to compare against
//   tc       - high while the count equals term
module gf180mcu_osu_sc_gp12t3v3__strap_cnt
  import gf180mcu_osu_sc_gp12t3v3__strap_pkg::*;
#(
  parameter int W = SETTLE_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__strap_ctrl.sv
// rtl/gf180mcu_osu_sc_gp12t3v3__strap_ctrl.sv - strap sampler and tie-off configuration controller
// Ports:
//   CLK      - clock, rising edge
//   RST      - synchronous active-high reset
//   STRAP_IN - asynchronous strap pins, double-flopped here
//   CFG_WE   - override write strobe, honoured only in DONE while unlocked
//   CFG_D    - override value
//   LOCK     - sticky lock request
//   Y        - registered configuration value
//   VALID    - Y is final (sampled or fallback)
//   FAULT    - sampling failed, Y fell back to DEFAULT
//   LOCKED   - sticky lock status
module gf180mcu_osu_sc_gp12t3v3__strap_ctrl
  import gf180mcu_osu_sc_gp12t3v3__strap_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               SETTLE    = 16,
  parameter int               MAX_RETRY = 3,
  parameter logic [WIDTH-1:0] DEFAULT   = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] STRAP_IN,
  input  logic             CFG_WE,
  input  logic [WIDTH-1:0] CFG_D,
  input  logic             LOCK,
  output logic [WIDTH-1:0] Y,
  output logic             VALID,
  output logic             FAULT,
  output logic             LOCKED
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_TERM = SETTLE_CNT_W'(SETTLE - 1);
  localparam logic [RETRY_CNT_W-1:0]  RETRY_TERM  = RETRY_CNT_W'(MAX_RETRY - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] y_d;
  logic             valid_d, fault_d;
  logic             settle_inc, settle_load, settle_tc;
  logic             retry_inc, retry_tc;

  // Settle window: counts while in SETTLE, cleared when a retry starts.
  gf180mcu_osu_sc_gp12t3v3__strap_cnt #(.W(SETTLE_CNT_W)) u_settle_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (settle_load),
    .load_val ('0),
    .inc      (settle_inc),
    .term     (SETTLE_TERM),
    .tc       (settle_tc)
  );

  // Retry budget: tc means the current attempt is the last one allowed.
  gf180mcu_osu_sc_gp12t3v3__strap_cnt #(.W(RETRY_CNT_W)) u_retry_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (1'b0),
    .load_val ('0),
    .inc      (retry_inc),
    .term     (RETRY_TERM),
    .tc       (retry_tc)
  );

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    y_d         = Y;
    valid_d     = VALID;
    fault_d     = FAULT;
    settle_inc  = 1'b0;
    settle_load = 1'b0;
    retry_inc   = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        settle_inc = 1'b1;
        if (settle_tc) state_d = ST_SAMPLE1;
      end
      ST_SAMPLE1: begin
        s1_d    = sync2;
        state_d = ST_SAMPLE2;
      end
      ST_SAMPLE2: begin
        if (sync2 == s1_q) begin
          y_d     = sync2;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (!retry_tc) begin
          retry_inc   = 1'b1;
          settle_load = 1'b1;
          state_d     = ST_SETTLE;
        end else begin
          y_d     = DEFAULT;
          valid_d = 1'b1;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // LOCKED is the registered value, so a write coinciding with the
        // lock request still lands.
        if (CFG_WE && !LOCKED) y_d = CFG_D;
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_SETTLE;
      sync1   <= DEFAULT;
      sync2   <= DEFAULT;
      s1_q    <= DEFAULT;
      Y       <= DEFAULT;
      VALID   <= 1'b0;
      FAULT   <= 1'b0;
      LOCKED  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1   <= STRAP_IN;
      sync2   <= sync1;
      s1_q    <= s1_d;
      Y       <= y_d;
      VALID   <= valid_d;
      FAULT   <= fault_d;
      LOCKED  <= LOCKED | LOCK;
    end
  end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__strap_ctrl.md
# gf180mcu_osu_sc_gp12t3v3__strap_ctrl

Strap sampler and tie-off configuration controller for the 12T 3.3 V cell set. After reset it drives a parameterised default pattern, the same role as tie-high and tie-low cells. It then waits a settle window, samples external strap pins until two consecutive samples match, and holds the result on its outputs. Software may override the held value until a sticky lock is set. Downstream macros take their configuration from `Y` instead of hard tie cells.

## Interface
- `WIDTH`, default 8: number of strap/config bits.
- `SETTLE`, default 16: cycles to wait before each sample attempt; legal range 1..255.
- `MAX_RETRY`, default 3: mismatching sample pairs tolerated before fallback; legal range 1..15.
- `DEFAULT`, default `{WIDTH{1'b1}}`: tie-off pattern driven during reset and on fallback.
- `CLK` input, 1 bit: single clock; all state updates on the rising edge.
- `RST` input, 1 bit: reset, synchronous and active-high.
- `STRAP_IN` input, `WIDTH` bits: external strap pins; asynchronous to `CLK`; double-flopped internally.
- `CFG_WE` input, 1 bit: override write strobe.
- `CFG_D` input, `WIDTH` bits: override value.
- `LOCK` input, 1 bit: lock request; once sampled high, lock is sticky until `RST`.
- `Y` output, `WIDTH` bits: configuration value, registered.
- `VALID` output, 1 bit: `Y` is final, either sampled or fallback.
- `FAULT` output, 1 bit: strap sampling failed and `Y` holds `DEFAULT`.
- `LOCKED` output, 1 bit: sticky lock status.

## Operation
- **Reset values** (while `RST`=1 at an edge): `Y`=`DEFAULT`, `VALID`=0, `FAULT`=0, `LOCKED`=0, state=SETTLE, settle counter=0, retry counter=0, synchroniser flops=`DEFAULT`.
- **SETTLE**: counter increments each cycle. When counter = `SETTLE`-1, go to SAMPLE1.
- **SAMPLE1**: capture the synchronised strap value into `s1`. Go to SAMPLE2.
- **SAMPLE2**: compare the synchronised strap value with `s1`.
  - Equal: load `Y` with it, set `VALID`=1, go to DONE.
  - Unequal, retry counter < `MAX_RETRY`-1: increment retry counter, clear settle counter, go to SETTLE.
  - Unequal, retries exhausted: `Y`=`DEFAULT`, `VALID`=1, `FAULT`=1, go to DONE.
- **DONE**: terminal until `RST`. `STRAP_IN` is ignored.
  - `CFG_WE`=1 and `LOCKED`=0: `Y`<=`CFG_D`.
  - `CFG_WE` outside DONE is ignored; no queuing.
- **Lock**: `LOCKED`<=1 on any edge with `LOCK`=1, in any state. Once locked, `CFG_WE` has no effect.
  - `CFG_WE` and `LOCK` high on the same edge while unlocked: the write takes effect and the lock applies from the next edge.
- `FAULT` is not cleared by overrides. Only `RST` clears it.
- **Reset mid-operation**: `RST` has priority over every transition, including a DONE write. Sampling restarts from SETTLE with the retry counter cleared.

## Timing
- Edge 1 is the first rising edge with `RST`=0.
- Clean straps: SAMPLE1 occurs at edge `SETTLE`+1. `Y` and `VALID` update at edge `SETTLE`+2, visible after it.
- Each retry adds `SETTLE`+2 cycles.
- Fallback `VALID` at edge `MAX_RETRY`×(`SETTLE`+2).
- Override latency: one cycle, `CFG_WE` at edge n gives `Y`=`CFG_D` after edge n.
- Synchroniser adds 2 cycles of strap latency. The settle window covers it when `SETTLE`≥2; for `SETTLE`=1 the first sample may read the reset value of the synchroniser flops.
- `Y` changes only at reset, at SAMPLE2 resolution, or on an accepted override. It is glitch-free (registered output).

## Structure
- Package `gf180mcu_osu_sc_gp12t3v3__strap_pkg` holds:
  - the state enum (SETTLE, SAMPLE1, SAMPLE2, DONE), 2-bit encoding;
  - the settle counter width constant (8) and retry counter width constant (4).
- Sub-module `gf180mcu_osu_sc_gp12t3v3__strap_cnt`: loadable up-counter with terminal-count flag, instantiated for both the settle counter and the retry counter.
- The two-flop synchroniser is inline in the top level.

## Test plan
- **Clean sample**: `WIDTH`=8, `SETTLE`=4, `STRAP_IN`=0x5A stable -> `Y`=0xFF through edge 5, `Y`=0x5A and `VALID`=1 after edge 6, `FAULT`=0.
- **One retry**: `STRAP_IN` toggles 0x5A to 0x3C exactly between SAMPLE1 and SAMPLE2 on the first attempt, then holds 0x3C -> `VALID` rises after edge 12 with `Y`=0x3C.
- **Fallback**: `STRAP_IN` toggles every cycle, `MAX_RETRY`=3 -> after edge 18, `Y`=0xFF, `VALID`=1, `FAULT`=1.
- **Override and lock**: in DONE, `CFG_WE`=1 with `CFG_D`=0xA5 -> `Y`=0xA5 next cycle. Then `LOCK`=1 for one cycle, then `CFG_WE`=1 with `CFG_D`=0x00 -> `Y` stays 0xA5, `LOCKED`=1.
- **Simultaneous write and lock**: `CFG_WE`, `LOCK` both high with `CFG_D`=0x11 -> `Y`=0x11, `LOCKED`=1. A subsequent write is ignored.
- **Reset mid-operation**: assert `RST` during SAMPLE2, and separately during DONE with `LOCKED`=1 -> all outputs return to their reset values next cycle, and a clean resample completes after `SETTLE`+2 edges.
